// File: rtl/imm_ext_pkg.sv
// Shared types and default widths for the immediate extend unit.
package imm_ext_pkg;

    localparam int unsigned IMM_IN_W  = 16;
    localparam int unsigned IMM_OUT_W = 32;

    typedef enum logic [1:0] {
        MODE_SIGN   = 2'b00,
        MODE_ZERO   = 2'b01,
        MODE_UPPER  = 2'b10,
        MODE_BRANCH = 2'b11
    } imm_mode_e;

    // Skid buffer occupancy; encoding 2'b11 is unused.
    typedef enum logic [1:0] {
        OccEmpty = 2'd0,
        OccOne   = 2'd1,
        OccFull  = 2'd2
    } occ_e;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extension: sign, zero, upper (LUI-style) and shifted branch offset.
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int unsigned IN_W     = IMM_IN_W,
    parameter int unsigned OUT_W    = IMM_OUT_W,
    parameter int unsigned BR_SHIFT = 2
) (
    input  logic [IN_W-1:0]  imm,
    input  imm_mode_e        mode,
    output logic [OUT_W-1:0] ext
);

    if (IN_W < 1 || IN_W > OUT_W) begin : g_bad_in_w
        $error("imm_ext_core: IN_W must be in 1..OUT_W");
    end
    if (BR_SHIFT >= OUT_W) begin : g_bad_br_shift
        $error("imm_ext_core: BR_SHIFT must be below OUT_W");
    end

    logic [OUT_W-1:0] sign_ext;
    logic [OUT_W-1:0] zero_ext;
    logic [OUT_W-1:0] upper_ext;
    logic [OUT_W-1:0] branch_ext;

    // Size casts stay legal when IN_W == OUT_W, unlike a zero-count replication.
    assign sign_ext   = OUT_W'($signed(imm));
    assign zero_ext   = OUT_W'(imm);
    assign upper_ext  = zero_ext << (OUT_W - IN_W);
    assign branch_ext = sign_ext << BR_SHIFT;

    always_comb begin
        ext = sign_ext;
        unique case (mode)
            MODE_SIGN:   ext = sign_ext;
            MODE_ZERO:   ext = zero_ext;
            MODE_UPPER:  ext = upper_ext;
            MODE_BRANCH: ext = branch_ext;
        endcase
    end

endmodule

// File: rtl/imm_extend_unit.sv
// Pipelined immediate extender with a 2-entry skid buffer and valid/ready handshakes.
// Define IMM_EXT_CNT_EN to add the xfer_cnt output-transfer counter port.
module imm_extend_unit
    import imm_ext_pkg::*;
#(
    parameter int unsigned IN_W     = IMM_IN_W,
    parameter int unsigned OUT_W    = IMM_OUT_W,
    parameter int unsigned BR_SHIFT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_imm
`ifdef IMM_EXT_CNT_EN
    ,
    output logic [31:0]      xfer_cnt
`endif
);

    occ_e             occ_q, occ_d;
    logic [OUT_W-1:0] head_q, head_d;
    logic [OUT_W-1:0] skid_q, skid_d;
    logic             in_ready_q;
    logic [OUT_W-1:0] ext;
    logic             push;
    logic             pop;

    imm_ext_core #(
        .IN_W     (IN_W),
        .OUT_W    (OUT_W),
        .BR_SHIFT (BR_SHIFT)
    ) u_core (
        .imm  (in_imm),
        .mode (imm_mode_e'(in_mode)),
        .ext  (ext)
    );

    assign push      = in_valid & in_ready_q;
    assign pop       = out_valid & out_ready;
    assign out_valid = (occ_q != OccEmpty);
    assign out_imm   = head_q;
    assign in_ready  = in_ready_q;

    // ext is only captured on push, so idle X on in_imm/in_mode never reaches the registers.
    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        skid_d = skid_q;
        unique case (occ_q)
            OccEmpty: begin
                if (push) begin
                    head_d = ext;
                    occ_d  = OccOne;
                end
            end
            OccOne: begin
                if (push && pop) begin
                    head_d = ext;
                end else if (push) begin
                    skid_d = ext;
                    occ_d  = OccFull;
                end else if (pop) begin
                    occ_d = OccEmpty;
                end
            end
            OccFull: begin
                if (pop) begin
                    head_d = skid_q;
                    occ_d  = OccOne;
                end
            end
            default: occ_d = OccEmpty;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            occ_q      <= OccEmpty;
            head_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            occ_q      <= occ_d;
            head_q     <= head_d;
            skid_q     <= skid_d;
            in_ready_q <= (occ_d != OccFull);
        end
    end

`ifdef IMM_EXT_CNT_EN
    logic [31:0] xfer_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            xfer_cnt_q <= '0;
        end else if (pop) begin
            xfer_cnt_q <= xfer_cnt_q + 32'd1;
        end
    end

    assign xfer_cnt = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_imm_extend_unit.sv
// Scoreboard bench for imm_extend_unit: default 16->32 instance plus a 12->32, BR_SHIFT=1 instance.
module tb_imm_extend_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_imm = '0;
    logic [1:0]  in_mode = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_imm;

    logic        v12 = 1'b0;
    logic        rdy12;
    logic [11:0] imm12 = '0;
    logic [1:0]  mode12 = '0;
    logic        ov12;
    logic [31:0] out12;

`ifdef IMM_EXT_CNT_EN
    logic [31:0] xfer_cnt;
    logic [31:0] xfer_cnt12;
`endif

    int          n_checks = 0;
    int          n_errs = 0;
    logic [31:0] sb[$];
    int unsigned cyc = 0;
    int          n_out = 0;
    int          n12 = 0;
    bit          stall_q = 1'b0;
    logic [31:0] held = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    imm_extend_unit u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_imm    (in_imm),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_imm   (out_imm)
`ifdef IMM_EXT_CNT_EN
        ,
        .xfer_cnt  (xfer_cnt)
`endif
    );

    imm_extend_unit #(
        .IN_W     (12),
        .OUT_W    (32),
        .BR_SHIFT (1)
    ) u_dut12 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (v12),
        .in_ready  (rdy12),
        .in_imm    (imm12),
        .in_mode   (mode12),
        .out_valid (ov12),
        .out_ready (1'b1),
        .out_imm   (out12)
`ifdef IMM_EXT_CNT_EN
        ,
        .xfer_cnt  (xfer_cnt12)
`endif
    );

    // Reference: interpret the immediate as a number, then scale it arithmetically.
    function automatic logic [31:0] ref_ext(input logic [31:0] imm, input logic [1:0] mode,
                                            input int in_w, input int br);
        longint u, s;
        u = longint'(imm) & ((longint'(1) << in_w) - 1);
        s = (u >= (longint'(1) << (in_w - 1))) ? u - (longint'(1) << in_w) : u;
        case (mode)
            2'd0:    return 32'(s);
            2'd1:    return 32'(u);
            2'd2:    return 32'(u * (longint'(1) << (32 - in_w)));
            default: return 32'(s * (longint'(1) << br));
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Call just after a posedge; returns just after the edge where the beat transferred.
    task automatic send(input logic [15:0] imm, input logic [1:0] mode);
        bit done = 1'b0;
        in_valid = 1'b1;
        in_imm   = imm;
        in_mode  = mode;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
        end
        if (!done) begin
            n_checks++;
            n_errs++;
            $display("FAIL send_timeout: in_ready stayed 0, required 1 within 60 cycles");
            in_valid = 1'b0;
            return;
        end
        sync();
        in_valid = 1'b0;
        in_imm   = 'x;
        in_mode  = 'x;
    endtask

    task automatic do_reset(input int n);
        sync();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        v12      = 1'b0;
        sb.delete();
        n_out    = 0;
        n12      = 0;
        repeat (n) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: pops expected values on output transfers, pushes on input transfers.
    always @(negedge clk) begin
        if (rst_n) begin
            if (stall_q && out_valid) check("stall_stable", out_imm, held);
            else if (stall_q) check("stall_valid", 32'(out_valid), 32'd1);
            stall_q = out_valid && !out_ready;
            held    = out_imm;
            if (out_valid && out_ready) begin
                n_out++;
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errs++;
                    $display("FAIL sb_underflow: got %h, required no output", out_imm);
                end else begin
                    check("scoreboard", out_imm, sb.pop_front());
                end
            end
            if (in_valid && in_ready) sb.push_back(ref_ext(32'(in_imm), in_mode, 16, 2));
        end else begin
            stall_q = 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          rdy_done;
        int unsigned start;
        logic [11:0] r_imm;
        logic [1:0]  r_mode;
        logic [31:0] exp12;

        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_imm", out_imm, 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        sync();

        // Directed modes with one-cycle latency.
        out_ready = 1'b1;
        send(16'h8001, 2'd0);
        @(negedge clk);
        check("t1_latency_valid", 32'(out_valid), 32'd1);
        check("t1_sign", out_imm, 32'hFFFF8001);
        sync();
        send(16'h8001, 2'd1);
        @(negedge clk);
        check("t2_zero", out_imm, 32'h00008001);
        sync();
        send(16'h1234, 2'd2);
        @(negedge clk);
        check("t2_upper", out_imm, 32'h12340000);
        sync();
        send(16'hFFFF, 2'd3);
        @(negedge clk);
        check("t2_branch", out_imm, 32'hFFFFFFFC);
        sync();
        repeat (2) sync();

        // Back-pressure: two beats absorbed, third refused until drain.
        out_ready = 1'b0;
        send(16'hA5A5, 2'd0);
        send(16'h0F0F, 2'd1);
        in_valid = 1'b1;
        in_imm   = 16'h00C3;
        in_mode  = 2'd2;
        repeat (3) begin
            @(negedge clk);
            check("t3_full_in_ready", 32'(in_ready), 32'd0);
            sync();
        end
        out_ready = 1'b1;
        send(16'h00C3, 2'd2);
        repeat (4) sync();
        check("t3_drained", 32'(sb.size()), 32'd0);

        // Streaming at full rate.
        start = cyc;
        repeat (100) send(16'($urandom), 2'($urandom_range(0, 3)));
        check("t4_cycles", cyc - start, 32'd100);

        // Random back-pressure.
        rdy_done = 1'b0;
        fork
            begin
                repeat (100) send(16'($urandom), 2'($urandom_range(0, 3)));
                rdy_done = 1'b1;
            end
            begin
                while (!rdy_done) begin
                    sync();
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        repeat (4) sync();
        check("t4_drained", 32'(sb.size()), 32'd0);
`ifdef IMM_EXT_CNT_EN
        check("xfer_cnt", xfer_cnt, 32'(n_out));
`endif

        // Reset while full.
        out_ready = 1'b0;
        send(16'h0001, 2'd0);
        send(16'h0002, 2'd0);
        @(negedge clk);
        check("t5_full", 32'(in_ready), 32'd0);
        do_reset(1);
        @(negedge clk);
        check("t5_out_valid", 32'(out_valid), 32'd0);
        check("t5_out_imm", out_imm, 32'd0);
        check("t5_in_ready", 32'(in_ready), 32'd1);
`ifdef IMM_EXT_CNT_EN
        check("t5_xfer_cnt", xfer_cnt, 32'd0);
`endif
        out_ready = 1'b1;
        sync();

        // 12->32, BR_SHIFT=1 instance.
        v12    = 1'b1;
        imm12  = 12'h800;
        mode12 = 2'd0;
        sync();
        n12++;
        @(negedge clk);
        check("t6_sign", out12, 32'hFFFFF800);
        mode12 = 2'd3;
        sync();
        n12++;
        @(negedge clk);
        check("t6_branch", out12, 32'hFFFFF000);
        for (int i = 0; i < 20; i++) begin
            r_imm  = 12'($urandom);
            r_mode = 2'($urandom_range(0, 3));
            imm12  = r_imm;
            mode12 = r_mode;
            exp12  = ref_ext(32'(r_imm), r_mode, 12, 1);
            sync();
            n12++;
            @(negedge clk);
            check("t6_random", out12, exp12);
        end
        v12 = 1'b0;
        sync();
        @(negedge clk);
        check("t6_idle_valid", 32'(ov12), 32'd0);
`ifdef IMM_EXT_CNT_EN
        check("t6_xfer_cnt", xfer_cnt12, 32'(n12));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
